seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the Basys3 4-digit 7-segment display. The four digits share one set of segment lines, and this block schedules them. It takes a 16-bit hex value from the user design over a valid/ready handshake and holds it in a one-entry buffer. The value is committed only on a frame boundary, so no digit tears mid-scan. It then drives `seg`/`dp`/`an` in the board top in place of the tied-off constants.

---
 rtl/seg7_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Scan controller for a 4-digit, common-anode 7-segment display. Values are double-buffered and committed only on a frame boundary.
// Optional build macro SEG7_LZB_EN turns on leading-zero blanking.
module seg7_scan_ctrl #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int GUARD        = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    input  logic        value_valid,
    output logic        value_ready,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int CNT_W = $clog2(DIGIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);

    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       dig_reg;
    logic [15:0]      disp_val_reg;
    logic [3:0]       disp_dp_reg;
    logic [15:0]      hold_val_reg;
    logic [3:0]       hold_dp_reg;
    logic             pending_reg;
    logic [6:0]       seg_reg;
    logic             dp_reg;
    logic [3:0]       an_reg;
    logic             frame_tick_reg;

    logic             slot_wrap;
    logic             frame_edge;
    logic             accept;
    logic             in_guard;
    logic             blank;
    logic [3:0]       cur_nib;
    logic [3:0]       dig_onehot;
    logic [6:0]       seg_next;
    logic             dp_next;
    logic [3:0]       an_next;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign slot_wrap   = (cnt_reg == CNT_LAST);
    assign frame_edge  = slot_wrap && (dig_reg == 2'd3);
    assign accept      = value_valid && !pending_reg;
    assign value_ready = !pending_reg;
    assign in_guard    = (GUARD == 0) ? 1'b0 : (cnt_reg < CNT_GUARD);
    assign cur_nib     = disp_val_reg[{dig_reg, 2'b00} +: 4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_onehot
            assign dig_onehot[gi] = (dig_reg == 2'(gi));
        end
    endgenerate

`ifdef SEG7_LZB_EN
    // lead_zero[k]: nibble k and every nibble above it are zero
    logic [3:0] nib_zero;
    logic [3:0] lead_zero;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_nib_zero
            assign nib_zero[gi] = (disp_val_reg[4*gi +: 4] == 4'h0);
        end
        assign lead_zero[3] = nib_zero[3];
        for (gi = 0; gi < 3; gi++) begin : g_lead_zero
            assign lead_zero[gi] = nib_zero[gi] && lead_zero[gi+1];
        end
    endgenerate
    assign blank = (dig_reg != 2'd0) && lead_zero[dig_reg];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        seg_next = hex7(cur_nib);
        an_next  = (in_guard || blank) ? 4'hF : ~dig_onehot;
        dp_next  = blank ? 1'b1 : ~disp_dp_reg[dig_reg];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg        <= '0;
            dig_reg        <= 2'd0;
            disp_val_reg   <= 16'h0000;
            disp_dp_reg    <= 4'h0;
            hold_val_reg   <= 16'h0000;
            hold_dp_reg    <= 4'h0;
            pending_reg    <= 1'b0;
            seg_reg        <= 7'h7F;
            dp_reg         <= 1'b1;
            an_reg         <= 4'hF;
            frame_tick_reg <= 1'b0;
        end else begin
            cnt_reg        <= slot_wrap ? '0 : cnt_reg + 1'b1;
            dig_reg        <= slot_wrap ? dig_reg + 2'd1 : dig_reg;
            frame_tick_reg <= frame_edge;
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            an_reg         <= an_next;
            // Commit and accept are mutually exclusive: accept needs an empty buffer
            if (frame_edge && pending_reg) begin
                disp_val_reg <= hold_val_reg;
                disp_dp_reg  <= hold_dp_reg;
                pending_reg  <= 1'b0;
            end else if (accept) begin
                hold_val_reg <= value;
                hold_dp_reg  <= dp_mask;
                pending_reg  <= 1'b1;
            end
        end
    end

    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign an         = an_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIGIT_CYCLES = 8, GUARD = 2.
module tb_seg7_scan_ctrl;

    localparam int DC = 8;
    localparam int GD = 2;
`ifdef SEG7_LZB_EN
    localparam logic [3:0] DRV_LZ = 4'b0001;
`else
    localparam logic [3:0] DRV_LZ = 4'b1111;
`endif

    logic        clock;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        value_valid;
    logic        value_ready;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int n_vec;
    int n_bad;

    typedef struct {
        logic [15:0]     val;
        logic [3:0]      dpm;
        logic [3:0][6:0] segx;
        logic [3:0]      dpx;
    } vec_t;

    vec_t vecs[5];

    seg7_scan_ctrl #(.DIGIT_CYCLES(DC), .GUARD(GD)) dut (
        .clock(clock),
        .reset(reset),
        .value(value),
        .dp_mask(dp_mask),
        .value_valid(value_valid),
        .value_ready(value_ready),
        .seg(seg),
        .dp(dp),
        .an(an),
        .frame_tick(frame_tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int s, input int c,
                       input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s slot=%0d cyc=%0d got=%h exp=%h", name, s, c, got, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_an", 0, 0, 8'(an), 8'hF);
        chk("rst_seg", 0, 0, 8'(seg), 8'h7F);
        chk("rst_dp", 0, 0, 8'(dp), 8'h1);
        chk("rst_tick", 0, 0, 8'(frame_tick), 8'h0);
        chk("rst_ready", 0, 0, 8'(value_ready), 8'h1);
    endtask

    // Steps 32 cycles starting just after a frame boundary; ends on the next frame_tick cycle.
    task automatic check_frame(input logic [3:0][6:0] es, input logic [3:0] edp,
                               input logic [3:0] drive, input logic exp_rdy);
        logic [3:0] exp_an;
        logic       last;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < DC; c++) begin
                @(negedge clock);
                last = (s == 3) && (c == DC - 1);
                chk("frame_tick", s, c, 8'(frame_tick), 8'(last));
                chk("value_ready", s, c, 8'(value_ready), last ? 8'h1 : 8'(exp_rdy));
                exp_an = 4'hF;
                if (drive[s] && c >= GD) exp_an[s] = 1'b0;
                chk("an", s, c, 8'(an), 8'(exp_an));
                if (!drive[s]) begin
                    chk("dp_blank", s, c, 8'(dp), 8'h1);
                end else if (c >= GD) begin
                    chk("seg", s, c, 8'(seg), 8'(es[s]));
                    chk("dp", s, c, 8'(dp), 8'(edp[s]));
                end
            end
        end
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] m);
        value       = v;
        dp_mask     = m;
        value_valid = 1'b1;
        @(negedge clock);
        value_valid = 1'b0;
        chk("ready_after_accept", 0, 0, 8'(value_ready), 8'h0);
    endtask

    task automatic wait_tick(input int budget);
        logic got;
        got = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clock);
            if (frame_tick) begin
                got = 1'b1;
                break;
            end
            chk("ready_while_pending", 0, n, 8'(value_ready), 8'h0);
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL frame_tick_timeout got=none exp=pulse within %0d cycles", budget);
        end
    endtask

    initial begin
        n_vec       = 0;
        n_bad       = 0;
        reset       = 1'b0;
        value       = 16'h0;
        dp_mask     = 4'h0;
        value_valid = 1'b0;

        vecs[0] = '{16'h1A8F, 4'b0001, {7'h79, 7'h08, 7'h00, 7'h0E}, 4'b1110};
        vecs[1] = '{16'h1234, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
        vecs[2] = '{16'h5678, 4'b1010, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b0101};
        vecs[3] = '{16'h9BCD, 4'b1111, {7'h10, 7'h03, 7'h46, 7'h21}, 4'b0000};
        vecs[4] = '{16'hE0E0, 4'b0100, {7'h06, 7'h40, 7'h06, 7'h40}, 4'b1011};

        // Power-on reset, checked before any clock edge
        #1 reset = 1'b1;
        #1 chk_reset_outputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_frame({4{7'h40}}, 4'hF, DRV_LZ, 1'b1);

        for (int i = 0; i < 5; i++) begin
            load(vecs[i].val, vecs[i].dpm);
            wait_tick(40);
            chk("ready_at_tick", i, 0, 8'(value_ready), 8'h1);
            check_frame(vecs[i].segx, vecs[i].dpx, 4'hF, 1'b1);
        end

        // Mid-frame asynchronous reset clears the display back to 0000
        repeat (13) @(negedge clock);
        #2 reset = 1'b1;
        #1 chk_reset_outputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_frame({4{7'h40}}, 4'hF, DRV_LZ, 1'b1);

        // Back-to-back offers: second value waits for the commit of the first
        value       = 16'h1234;
        dp_mask     = 4'h0;
        value_valid = 1'b1;
        @(negedge clock);
        chk("b2b_ready_drop", 0, 0, 8'(value_ready), 8'h0);
        value = 16'h5678;
        dp_mask = 4'b1010;
        wait_tick(40);
        chk("b2b_ready_at_tick", 0, 0, 8'(value_ready), 8'h1);
        fork
            begin
                @(posedge clock);
                #1 value_valid = 1'b0;
            end
        join_none
        check_frame(vecs[1].segx, vecs[1].dpx, 4'hF, 1'b0);
        check_frame(vecs[2].segx, vecs[2].dpx, 4'hF, 1'b1);

        // Offer landing exactly on a boundary with an empty buffer
        repeat (DC * 4 - 1) @(negedge clock);
        value       = 16'h4321;
        dp_mask     = 4'h0;
        value_valid = 1'b1;
        @(negedge clock);
        value_valid = 1'b0;
        chk("coinc_tick", 0, 0, 8'(frame_tick), 8'h1);
        chk("coinc_ready", 0, 0, 8'(value_ready), 8'h0);
        check_frame(vecs[2].segx, vecs[2].dpx, 4'hF, 1'b0);
        check_frame({7'h19, 7'h30, 7'h24, 7'h79}, 4'hF, 4'hF, 1'b1);

        // Leading zeros: blanked only when the option is built in
        load(16'h0005, 4'h0);
        wait_tick(40);
        check_frame({7'h40, 7'h40, 7'h40, 7'h12}, 4'hF, DRV_LZ, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
